// File: rtl/lbp_scan_ctrl.sv
// Scan sequencer for the LBP engine: walks interior pixels, fetches each 3x3 neighbourhood
// with column reuse, and strobes the window datapath and the lbp result write.
module lbp_scan_ctrl #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned AW    = 14
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          gray_ready_i,
  output logic          gray_req_o,
  output logic [AW-1:0] gray_addr_o,
  output logic          win_wr_o,
  output logic [1:0]    win_row_o,
  output logic [1:0]    win_col_o,
  output logic          win_shift_o,
  output logic          lbp_valid_o,
  output logic [AW-1:0] lbp_addr_o,
  output logic          finish_o
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam logic [AW-1:0] WA = AW'(IMG_W);

  typedef enum logic [2:0] {StIdle, StPrime, StFetch, StCalc, StDone} state_e;

  state_e          st_q;
  logic [RW-1:0]   r_q;
  logic [CW-1:0]   c_q;
  logic [2:0]      k_q;

  logic            gray_req_q, win_wr_q, win_shift_q, lbp_valid_q, finish_q;
  logic [AW-1:0]   gray_addr_q, lbp_addr_q;
  logic [1:0]      win_row_q, win_col_q;

  logic [2:0]      k_m3;
  logic            prime_hi;
  logic [1:0]      f_row, f_col;
  logic [RW-1:0]   frow;
  logic [CW-1:0]   fcol;
  logic [AW-1:0]   fetch_addr, centre_addr;

  // Position of the fetch that would be issued at the coming edge.
  always_comb begin
    k_m3     = k_q - 3'd3;
    prime_hi = (k_q >= 3'd3);
    if (st_q == StFetch) begin
      f_row = k_q[1:0];
      f_col = 2'd2;
      fcol  = c_q + CW'(1);
    end else begin
      f_row = prime_hi ? k_m3[1:0] : k_q[1:0];
      f_col = prime_hi ? 2'd1 : 2'd0;
      fcol  = prime_hi ? CW'(1) : '0;
    end
    frow        = r_q + RW'(f_row) - RW'(1);
    fetch_addr  = AW'(frow) * WA + AW'(fcol);
    centre_addr = AW'(r_q) * WA + AW'(c_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q        <= StIdle;
      r_q         <= RW'(1);
      c_q         <= CW'(1);
      k_q         <= '0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      win_wr_q    <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_shift_q <= 1'b0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      gray_req_q  <= 1'b0;
      win_wr_q    <= 1'b0;
      win_shift_q <= 1'b0;
      lbp_valid_q <= 1'b0;
      unique case (st_q)
        StIdle, StPrime: begin
          if (gray_ready_i) begin
            gray_req_q  <= 1'b1;
            win_wr_q    <= 1'b1;
            gray_addr_q <= fetch_addr;
            win_row_q   <= f_row;
            win_col_q   <= f_col;
            if (k_q == 3'd5) begin
              k_q  <= '0;
              c_q  <= CW'(1);
              st_q <= StFetch;
            end else begin
              k_q  <= k_q + 3'd1;
              st_q <= StPrime;
            end
          end
        end
        StFetch: begin
          if (gray_ready_i) begin
            gray_req_q  <= 1'b1;
            win_wr_q    <= 1'b1;
            gray_addr_q <= fetch_addr;
            win_row_q   <= f_row;
            win_col_q   <= f_col;
            if (k_q == 3'd2) begin
              k_q  <= '0;
              st_q <= StCalc;
            end else begin
              k_q <= k_q + 3'd1;
            end
          end
        end
        StCalc: begin
          lbp_valid_q <= 1'b1;
          win_shift_q <= 1'b1;
          lbp_addr_q  <= centre_addr;
          if (c_q < CW'(IMG_W - 2)) begin
            c_q  <= c_q + CW'(1);
            st_q <= StFetch;
          end else if (r_q < RW'(IMG_H - 2)) begin
            r_q  <= r_q + RW'(1);
            c_q  <= CW'(1);
            st_q <= StPrime;
          end else begin
            st_q <= StDone;
          end
        end
        StDone: finish_q <= 1'b1;
        default: st_q <= StIdle;
      endcase
    end
  end

  assign gray_req_o  = gray_req_q;
  assign gray_addr_o = gray_addr_q;
  assign win_wr_o    = win_wr_q;
  assign win_row_o   = win_row_q;
  assign win_col_o   = win_col_q;
  assign win_shift_o = win_shift_q;
  assign lbp_valid_o = lbp_valid_q;
  assign lbp_addr_o  = lbp_addr_q;
  assign finish_o    = finish_q;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Directed bench for lbp_scan_ctrl: default 128x128 scan with memory and window model,
// plus a 4x4 instance.
module tb_lbp_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy;
  logic        req, wr, shift, valid, fin;
  logic [13:0] addr, laddr;
  logic [1:0]  row, col;

  logic        rst_s, rdy_s;
  logic        req_s, wr_s, shift_s, valid_s, fin_s;
  logic [3:0]  addr_s, laddr_s;
  logic [1:0]  row_s, col_s;

  lbp_scan_ctrl dut (
    .clk_i(clk), .reset_i(rst), .gray_ready_i(rdy),
    .gray_req_o(req), .gray_addr_o(addr), .win_wr_o(wr), .win_row_o(row), .win_col_o(col),
    .win_shift_o(shift), .lbp_valid_o(valid), .lbp_addr_o(laddr), .finish_o(fin)
  );

  lbp_scan_ctrl #(.IMG_W(4), .IMG_H(4), .AW(4)) dut_s (
    .clk_i(clk), .reset_i(rst_s), .gray_ready_i(rdy_s),
    .gray_req_o(req_s), .gray_addr_o(addr_s), .win_wr_o(wr_s), .win_row_o(row_s),
    .win_col_o(col_s), .win_shift_o(shift_s), .lbp_valid_o(valid_s), .lbp_addr_o(laddr_s),
    .finish_o(fin_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] img [0:16383];
  logic [7:0] res [0:16383];
  logic [7:0] win [0:2][0:2];

  int cyc, first_req, first_lbp, last_lbp, n_valid, n_border;
  int bad_wr, bad_excl, bad_shift, bad_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lbp_calc(input logic [71:0] px);
    logic [7:0] v;
    logic [7:0] c;
    int b;
    c = px[39:32];
    v = '0;
    b = 0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) begin
        v[b] = (px[8*i +: 8] >= c);
        b++;
      end
    end
    return v;
  endfunction

  function automatic logic [7:0] golden(input int a);
    logic [71:0] px;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        px[8*(r*3+c) +: 8] = img[(a / 128 + r - 1) * 128 + (a % 128) + c - 1];
    return lbp_calc(px);
  endfunction

  function automatic bit is_border(input int a);
    return (a / 128 == 0) || (a / 128 == 127) || (a % 128 == 0) || (a % 128 == 127);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16384; i++) res[i] = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) win[r][c] = '0;
    first_req = -1; first_lbp = -1; last_lbp = -1;
    n_valid = 0; n_border = 0;
    bad_wr = 0; bad_excl = 0; bad_shift = 0; bad_idx = 0;
  endtask

  // One cycle: sample the default DUT mid-cycle and advance the memory/window model.
  task automatic step();
    logic [71:0] px;
    @(negedge clk);
    cyc++;
    if (req !== wr) bad_wr++;
    if (req && valid) bad_excl++;
    if (shift && !valid) bad_shift++;
    if (valid) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) px[8*(r*3+c) +: 8] = win[r][c];
      res[laddr] = lbp_calc(px);
      n_valid++;
      if (first_lbp < 0) first_lbp = int'(laddr);
      last_lbp = int'(laddr);
      if (is_border(int'(laddr))) n_border++;
    end
    if (shift) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] = win[r][1];
        win[r][1] = win[r][2];
      end
    end
    if (req) begin
      if (row > 2'd2 || col > 2'd2) bad_idx++;
      else win[row][col] = img[addr];
      if (first_req < 0) first_req = cyc;
    end
  endtask

  task automatic fetch_chk(input string tag, input int a, input int rw, input int cl);
    step();
    check({tag, "_req"}, 32'(req), 1);
    check({tag, "_addr"}, 32'(addr), a);
    check({tag, "_row"}, 32'(row), rw);
    check({tag, "_col"}, 32'(col), cl);
  endtask

  task automatic zero_chk(input string tag);
    check({tag, "_req"}, 32'(req), 0);
    check({tag, "_wr"}, 32'(wr), 0);
    check({tag, "_addr"}, 32'(addr), 0);
    check({tag, "_rowcol"}, 32'({row, col}), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_shift"}, 32'(shift), 0);
    check({tag, "_laddr"}, 32'(laddr), 0);
    check({tag, "_finish"}, 32'(fin), 0);
  endtask

  initial begin
    int found, nreq, saved, fin_cyc, stalled, bad, fin_drop, bad_s;
    int q[$];
    logic [7:0] exp_px;

    for (int i = 0; i < 16384; i++) img[i] = 8'((i * 37) ^ ((i >> 4) * 11));
    cyc = 0;
    clear_model();
    rst = 1'b1; rdy = 1'b0; rst_s = 1'b1; rdy_s = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    zero_chk("reset");
    nreq = 0;
    repeat (10) begin
      step();
      if (req || valid || fin) nreq++;
    end
    check("idle_no_req", nreq, 0);
    zero_chk("idle");

    rdy = 1'b1;
    for (int k = 0; k < 6; k++) fetch_chk("prime_r1", (k % 3) * 128 + k / 3, k % 3, k / 3);
    for (int k = 0; k < 3; k++) fetch_chk("fetch_c1", k * 128 + 2, k, 2);
    step();
    check("calc1_valid", 32'(valid), 1);
    check("calc1_laddr", 32'(laddr), 129);
    check("calc1_shift", 32'(shift), 1);
    check("calc1_req", 32'(req), 0);
    for (int k = 0; k < 3; k++) fetch_chk("fetch_c2", k * 128 + 3, k, 2);

    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      step();
      if (valid && laddr == 14'd254) found = 1;
    end
    check("row1_last_calc", found, 1);
    for (int k = 0; k < 6; k++) fetch_chk("prime_r2", 128 + (k % 3) * 128 + k / 3, k % 3, k / 3);
    fetch_chk("fetch_r2_k0", 130, 0, 2);

    // Reset for one cycle in the middle of a FETCH.
    rst = 1'b1;
    step();
    zero_chk("midreset");
    clear_model();
    rst = 1'b0;
    fetch_chk("restart", 0, 0, 0);

    // Full scan, with one 5-cycle stall dropped in at a FETCH k=1 a few rows in.
    fin_cyc = -1;
    stalled = 0;
    for (int i = 0; i < 70000 && fin_cyc < 0; i++) begin
      step();
      if (fin) fin_cyc = cyc;
      if (stalled == 0 && req && col == 2'd2 && row == 2'd1 && cyc - first_req > 2000) begin
        stalled = 1;
        saved = int'(addr);
        rdy = 1'b0;
        nreq = 0;
        repeat (5) begin
          step();
          if (req || wr) nreq++;
        end
        rdy = 1'b1;
        check("stall_quiet", nreq, 0);
        step();
        check("stall_resume_req", 32'(req), 1);
        check("stall_resume_addr", 32'(addr), saved + 128);
      end
    end
    check("finish_seen", 32'(fin_cyc >= 0), 1);
    check("finish_latency", fin_cyc - first_req, 64265);
    check("lbp_count", n_valid, 15876);
    check("first_laddr", first_lbp, 129);
    check("last_laddr", last_lbp, 16254);
    check("border_writes", n_border, 0);
    check("wr_eq_req", bad_wr, 0);
    check("req_valid_excl", bad_excl, 0);
    check("shift_wo_valid", bad_shift, 0);
    check("win_index", bad_idx, 0);
    bad = 0;
    for (int a = 0; a < 16384; a++) begin
      exp_px = is_border(a) ? 8'd0 : golden(a);
      if (res[a] !== exp_px) bad++;
    end
    check("image_golden", bad, 0);
    fin_drop = 0;
    repeat (5) begin
      step();
      if (!fin || req || valid || shift) fin_drop++;
    end
    check("finish_held", fin_drop, 0);

    // 4x4 image: four centres, then finish.
    @(negedge clk);
    rst_s = 1'b0;
    rdy_s = 1'b1;
    bad_s = 0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (valid_s) q.push_back(int'(laddr_s));
      if (req_s && valid_s) bad_s++;
      if (fin_s) found = 1;
    end
    check("s_finish", found, 1);
    check("s_count", q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("s_laddr", (i < q.size()) ? q[i] : 32'hffff, (i < 2) ? 5 + i : 7 + i);
    check("s_excl", bad_s, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
